btn_debounce_scheduler: RTL
===========================

# btn_debounce_scheduler

Shared debounce scheduler for the board push-buttons. It generates the sample-enable strobe that paces debouncing and filters BTN_COUNT raw button inputs through per-button stability counters. Debounced press events are serialized onto one valid/ready event port by a round-robin arbiter. It sits between the raw button pins and the control FSMs, replacing one free-running debouncer instance per button.

## Interface
- BTN_COUNT, 4: number of buttons; 2..16.
- PRESCALE, 1000: clk cycles per sample tick; ≥2.
- STABLE_TICKS, 5: consecutive disagreeing ticks needed to change a debounced level; ≥1.
- ID_W, $clog2(BTN_COUNT): width of evt_id (localparam).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- btn_in  in  BTN_COUNT  raw, asynchronous, bouncing button levels; 1 = pressed.
- sample_tick  out  1  one-cycle strobe every PRESCALE cycles; usable as CLOCK_ENABLE for external debouncers.
- btn_level  out  BTN_COUNT  debounced level per button.
- evt_valid  out  1  event offered.
- evt_ready  in  1  consumer accepts event when evt_valid & evt_ready.
- evt_id  out  ID_W  index of the button that produced the event.
- evt_press  out  1  1 = press event, 0 = release event.
- evt_overrun  out  1  sticky: an edge was dropped because that button already had a pending event.

## Operation
- Synchronizer: two flops per btn_in bit; only btn_sync is used downstream.
- Prescaler: counter runs 0..PRESCALE-1 and wraps. sample_tick = 1 in the cycle the counter equals PRESCALE-1.
- Per-button filter, evaluated only on sample_tick:
  - btn_sync == btn_level: cnt ← 0.
  - Otherwise, if cnt == STABLE_TICKS-1: btn_level ← btn_sync, cnt ← 0.
  - Otherwise: cnt ← cnt+1.
  - Saturation is impossible by construction.
- Pending flags: a 0→1 btn_level change sets pend[i].
  - If pend[i] is already set and not being cleared that cycle, the edge is dropped and evt_overrun ← 1.
  - If the set coincides with acceptance of event i, the set wins: pend[i] stays 1.
- Arbiter FSM:
  - IDLE: if any pend, pick the first set index searching upward from rr_ptr with wrap. Latch it into evt_id, evt_valid ← 1, go to OFFER.
  - OFFER: evt_id and evt_press hold stable while evt_valid & !evt_ready. On acceptance: pend[evt_id] ← 0, rr_ptr ← evt_id+1 (wraps BTN_COUNT-1→0), evt_valid ← 0, go to IDLE.
  - A pending flag is never cleared without an accepted handshake.
  - Back-to-back events are separated by one IDLE cycle.
- Reset (async assert, sync-released by flops): prescaler, cnt, btn_level, pend, rr_ptr, evt_valid, evt_id, evt_overrun all 0; evt_press 1; sample_tick 0. Reset mid-OFFER drops the offered event and all pending events.

## Timing
- btn_in→btn_sync: 2 cycles.
- btn_sync stable→btn_level change: between (STABLE_TICKS-1)·PRESCALE+1 and STABLE_TICKS·PRESCALE cycles, counted to the next tick boundary.
- btn_level edge→pend set: same cycle as the level update (registered together).
- pend set→evt_valid: 1 cycle if the FSM is in IDLE.
- Accept→next evt_valid: 2 cycles minimum (OFFER→IDLE→OFFER).
- A glitch shorter than STABLE_TICKS ticks never changes btn_level.

## Configuration
- DEBOUNCE_RELEASE_EVT_EN defined:
  - A 1→0 btn_level change sets a separate rel_pend[i]; overrun rules match pend.
  - The arbiter treats each button's press and release as one slot. Press is served first if both are pending.
  - evt_press reports the event type.
- Undefined: no release logic; only presses are queued; evt_press is constant 1.

## Test plan
Bench parameters: BTN_COUNT=4, PRESCALE=4, STABLE_TICKS=3, evt_ready=1 unless stated.
- Reset values: rst_n low for 3 cycles → all outputs match the reset values above; sample_tick first rises in cycle 3 after release, then every 4 cycles.
- Clean press: btn_in[0] 0→1 held 20 ticks → btn_level[0] rises within 9..12 cycles after btn_sync; exactly one event, evt_id=0, evt_press=1.
- Bounce rejection: btn_in[1] toggled every 6 cycles for 60 cycles, then 0 → btn_level[1] stays 0; no evt_valid.
- Round-robin: btn_in[1] and btn_in[3] rise in the same cycle, rr_ptr=0 → events id 1 then id 3 (2 cycles apart); repeat with rr_ptr=2 → id 3 then id 1.
- Back-pressure/overrun: evt_ready=0; press, release and re-press btn 2 → evt_valid held with evt_id=2 stable; evt_overrun=1; after evt_ready=1 exactly one event.
- Mid-offer reset: assert rst_n while evt_valid=1 → evt_valid=0 immediately (async); no event after release. With DEBOUNCE_RELEASE_EVT_EN: release btn 0 → event id 0, evt_press=0.

Source files
------------

// File: rtl/btn_debounce_scheduler.sv
// btn_debounce_scheduler
// Shared debounce scheduler for board push-buttons. A prescaler produces a
// sample strobe; each synchronized button runs a stability counter on that
// strobe, and debounced press edges are queued as pending flags that a
// round-robin arbiter serializes onto one valid/ready event port.
//
// Optional feature macro: DEBOUNCE_RELEASE_EVT_EN
//   defined   : release edges are queued too; evt_press reports the type
//   undefined : only press events; evt_press is constant 1
//
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   btn_in       raw asynchronous button levels (1 = pressed)
//   sample_tick  one-cycle strobe every PRESCALE cycles
//   btn_level    debounced level per button
//   evt_valid    event offered
//   evt_ready    consumer accepts when evt_valid & evt_ready
//   evt_id       index of the button that produced the event
//   evt_press    1 = press event, 0 = release event
//   evt_overrun  sticky: an edge was dropped due to an already pending event
module btn_debounce_scheduler #(
    parameter int unsigned  BTN_COUNT    = 4,
    parameter int unsigned  PRESCALE     = 1000,
    parameter int unsigned  STABLE_TICKS = 5,
    localparam int unsigned ID_W         = $clog2(BTN_COUNT)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BTN_COUNT-1:0] btn_in,
    output logic                 sample_tick,
    output logic [BTN_COUNT-1:0] btn_level,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [ID_W-1:0]      evt_id,
    output logic                 evt_press,
    output logic                 evt_overrun
);

    localparam int unsigned PS_W  = $clog2(PRESCALE);
    localparam int unsigned CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_OFFER
    } state_t;

    logic [BTN_COUNT-1:0] sync1_q, sync2_q;
    logic [PS_W-1:0]      presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic [CNT_W-1:0]     cnt_q [BTN_COUNT];
    logic [CNT_W-1:0]     cnt_d [BTN_COUNT];
    logic [BTN_COUNT-1:0] level_q, level_d;
    logic [BTN_COUNT-1:0] pend_q, pend_d;
    logic                 overrun_q, overrun_d;
    state_t               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [ID_W-1:0]      id_q, id_d;
    logic                 press_q, press_d;
    logic [ID_W-1:0]      rr_q, rr_d;
    logic [BTN_COUNT-1:0] slot;
    logic [BTN_COUNT-1:0] sel;
    logic                 accept;
    logic                 found;
    logic [ID_W-1:0]      pick;
`ifdef DEBOUNCE_RELEASE_EVT_EN
    logic [BTN_COUNT-1:0] rel_pend_q, rel_pend_d;
`endif

    // Two-flop synchronizer; only sync2_q is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler; the tick flop is high while the counter holds PRESCALE-1.
    always_comb begin
        presc_d = (presc_q == PS_W'(PRESCALE - 1)) ? '0 : presc_q + PS_W'(1);
        tick_d  = (presc_d == PS_W'(PRESCALE - 1));
    end

    // Per-button stability filter, advanced only on the sample tick.
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < BTN_COUNT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(STABLE_TICKS - 1)) begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Handshake decode: one-hot of the button whose event is being accepted.
    always_comb begin
        accept = (state_q == ST_OFFER) && evt_ready;
        sel    = '0;
        for (int i = 0; i < BTN_COUNT; i++) begin
            sel[i] = accept && (id_q == ID_W'(i));
        end
    end

    // Pending flags: a new edge wins over a simultaneous clear; an edge
    // arriving while its flag is still held is dropped and flagged.
    always_comb begin
        pend_d    = pend_q;
        overrun_d = overrun_q;
`ifdef DEBOUNCE_RELEASE_EVT_EN
        rel_pend_d = rel_pend_q;
`endif
        for (int i = 0; i < BTN_COUNT; i++) begin
            if (level_d[i] && !level_q[i]) begin
                if (pend_q[i] && !(sel[i] && press_q)) begin
                    overrun_d = 1'b1;
                end
                pend_d[i] = 1'b1;
            end else if (sel[i] && press_q) begin
                pend_d[i] = 1'b0;
            end
`ifdef DEBOUNCE_RELEASE_EVT_EN
            if (!level_d[i] && level_q[i]) begin
                if (rel_pend_q[i] && !(sel[i] && !press_q)) begin
                    overrun_d = 1'b1;
                end
                rel_pend_d[i] = 1'b1;
            end else if (sel[i] && !press_q) begin
                rel_pend_d[i] = 1'b0;
            end
`endif
        end
    end

    // Round-robin pick: first pending slot at or above rr_q, with wrap.
    always_comb begin
`ifdef DEBOUNCE_RELEASE_EVT_EN
        slot = pend_q | rel_pend_q;
`else
        slot = pend_q;
`endif
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < BTN_COUNT; k++) begin
            int j;
            j = int'(rr_q) + k;
            if (j >= int'(BTN_COUNT)) begin
                j = j - int'(BTN_COUNT);
            end
            if (!found && slot[ID_W'(j)]) begin
                found = 1'b1;
                pick  = ID_W'(j);
            end
        end
    end

    // Arbiter FSM next-state and registered event outputs.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        press_d = press_q;
        rr_d    = rr_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    valid_d = 1'b1;
                    id_d    = pick;
`ifdef DEBOUNCE_RELEASE_EVT_EN
                    press_d = pend_q[pick];
`else
                    press_d = 1'b1;
`endif
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    valid_d = 1'b0;
                    rr_d    = (id_q == ID_W'(BTN_COUNT - 1)) ? '0 : id_q + ID_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            level_q   <= '0;
            pend_q    <= '0;
            overrun_q <= 1'b0;
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            id_q      <= '0;
            press_q   <= 1'b1;
            rr_q      <= '0;
            for (int i = 0; i < BTN_COUNT; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef DEBOUNCE_RELEASE_EVT_EN
            rel_pend_q <= '0;
`endif
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            level_q   <= level_d;
            pend_q    <= pend_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            id_q      <= id_d;
            press_q   <= press_d;
            rr_q      <= rr_d;
            for (int i = 0; i < BTN_COUNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef DEBOUNCE_RELEASE_EVT_EN
            rel_pend_q <= rel_pend_d;
`endif
        end
    end

    assign sample_tick = tick_q;
    assign btn_level   = level_q;
    assign evt_valid   = valid_q;
    assign evt_id      = id_q;
    assign evt_press   = press_q;
    assign evt_overrun = overrun_q;

endmodule
